// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the 4x4 storage controller: FSM state encoding and
// default array geometry.
package ram_ctrl_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_ACCESS = 2'b01;
  localparam state_t ST_RESP   = 2'b10;

endpackage

// File: rtl/ram4x4.sv
// Small storage array: synchronous write, combinational read, and an
// asynchronous clear that zeroes every word.
module ram4x4
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_wen;

  // One-hot word enable decoded from the address.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wen
      assign w_wen[gi] = we && (addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wen[i]) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/ram4x4_arbiter.sv
// Round-robin two-port front end for the 4x4 array: each grant runs
// IDLE -> ACCESS -> RESP and returns a one-cycle ack with the word.
module ram4x4_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic              ack_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              ack_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy,
  output logic              gnt
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_prio;
  logic              r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;

  logic              w_any_req;
  logic              w_owner;
  logic              w_grant;
  logic              w_mem_we;
  logic [WIDTH-1:0]  w_mem_rdata;

  assign w_any_req = req_a | req_b;
  // prio only matters on a tie; a lone requester always wins.
  assign w_owner   = (req_a && req_b) ? r_prio : req_b;
  assign w_grant   = (r_state == ST_IDLE) && w_any_req;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_next = w_any_req ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Owner and request fields are frozen at the grant edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_prio  <= 1'b0;
      r_gnt   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_gnt   <= w_owner;
      r_prio  <= ~w_owner;
      r_we    <= w_owner ? we_b    : we_a;
      r_addr  <= w_owner ? addr_b  : addr_a;
      r_wdata <= w_owner ? wdata_b : wdata_a;
    end
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    ack_a    = 1'b0;
    ack_b    = 1'b0;
    rdata_a  = '0;
    rdata_b  = '0;
    w_mem_we = 1'b0;
    case (r_state)
      ST_ACCESS: w_mem_we = r_we;
      // After a write the array already holds wdata, so one read path
      // serves both kinds of access.
      ST_RESP: begin
        if (r_gnt) begin
          ack_b   = 1'b1;
          rdata_b = w_mem_rdata;
        end else begin
          ack_a   = 1'b1;
          rdata_a = w_mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign gnt = r_gnt;

  ram4x4 #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .clear (clear),
    .we    (w_mem_we),
    .addr  (r_addr),
    .wdata (r_wdata),
    .rdata (w_mem_rdata)
  );

endmodule
